// File: rtl/mem_cmd_responder_if.sv
// Command/response bundle between the front-panel I/O controller (master)
// and the memory-side responder (slave).
interface mem_cmd_responder_if #(
  parameter int unsigned DATA_W = 16
);
  logic [1:0]        modeOutput;
  logic [24:0]       memoryAddress;
  logic [DATA_W-1:0] ioDataOut;
  logic              ioDone;
  logic              memDone;
  logic [DATA_W-1:0] memOut;
  logic              errFlag;

  modport master (
    output modeOutput, memoryAddress, ioDataOut, ioDone,
    input  memDone, memOut, errFlag
  );

  modport slave (
    input  modeOutput, memoryAddress, ioDataOut, ioDone,
    output memDone, memOut, errFlag
  );
endinterface

// File: rtl/mem_cmd_responder.sv
// Memory-side responder: executes clear/read/write commands on an internal word RAM.
// Optional MEM_OOR_EN: reject addresses >= DEPTH and raise a sticky errFlag.
module mem_cmd_responder #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_cmd_responder_if.slave   bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, CLEAR} state_t;

  state_t            state_q;
  logic              io_done_q;
  logic              mem_done_q;
  logic [DATA_W-1:0] mem_out_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] ram [DEPTH];

  logic              req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

`ifdef MEM_OOR_EN
  logic oor;
  logic oor_q;
  logic err_q;
  assign oor         = |bus.memoryAddress[24:ADDR_W];
  assign bus.errFlag = err_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.memoryAddress[24:ADDR_W];
  assign bus.errFlag    = 1'b0;
`endif

  assign req         = bus.ioDone & ~io_done_q;
  assign bus.memDone = mem_done_q;
  assign bus.memOut  = mem_out_q;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr_q;
    ram_wdata = data_q;
    if (state_q == WRITE) begin
`ifdef MEM_OOR_EN
      ram_we = ~oor_q;
`else
      ram_we = 1'b1;
`endif
    end else if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_q;
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    if (state_q == RD_ADDR) rd_data_q <= ram[addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      io_done_q  <= 1'b0;
      mem_done_q <= 1'b1;
      mem_out_q  <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
`ifdef MEM_OOR_EN
      oor_q      <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      io_done_q <= bus.ioDone;
      case (state_q)
        IDLE: begin
          if (req && bus.modeOutput != 2'b11) begin
            addr_q     <= bus.memoryAddress[ADDR_W-1:0];
            data_q     <= bus.ioDataOut;
            mem_done_q <= 1'b0;
`ifdef MEM_OOR_EN
            // Rejected commands reuse WRITE as a one-cycle acknowledge with the write masked.
            oor_q <= oor;
            if (oor) err_q <= 1'b1;
            if (oor) state_q <= WRITE;
            else
`endif
            case (bus.modeOutput)
              2'b10:   state_q <= WRITE;
              2'b01:   state_q <= RD_ADDR;
              default: begin
                state_q <= CLEAR;
                cnt_q   <= '0;
              end
            endcase
          end
        end
        WRITE: begin
          state_q    <= IDLE;
          mem_done_q <= 1'b1;
        end
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: begin
          mem_out_q  <= rd_data_q;
          state_q    <= IDLE;
          mem_done_q <= 1'b1;
        end
        CLEAR: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == '1) begin
            state_q    <= IDLE;
            mem_done_q <= 1'b1;
            mem_out_q  <= '0;
`ifdef MEM_OOR_EN
            err_q      <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_cmd_responder.sv
// Directed self-checking bench for mem_cmd_responder (ADDR_W=4, DATA_W=16).
module tb_mem_cmd_responder;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_cmd_responder_if #(.DATA_W(16)) bus ();

  mem_cmd_responder #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Called at a negedge; returns at the negedge where memDone is back to 1.
  task automatic issue(input logic [1:0] mode, input logic [24:0] addr,
                       input logic [15:0] data, output int low);
    bus.modeOutput    = mode;
    bus.memoryAddress = addr;
    bus.ioDataOut     = data;
    bus.ioDone        = 1'b1;
    @(negedge clk);
    bus.ioDone = 1'b0;
    low = 0;
    while (bus.memDone !== 1'b1 && low < 50) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.modeOutput = 2'b11; bus.memoryAddress = '0; bus.ioDataOut = '0; bus.ioDone = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.memDone !== 1'b1) begin errors++; $display("FAIL reset_memDone: got %b expected 1", bus.memDone); end
    checks++; if (bus.memOut !== 16'h0000) begin errors++; $display("FAIL reset_memOut: got %h expected 0000", bus.memOut); end
    checks++; if (bus.errFlag !== 1'b0) begin errors++; $display("FAIL reset_errFlag: got %b expected 0", bus.errFlag); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int low;
    issue(2'b10, 25'd3, 16'hBEEF, low);
    checks++; if (low !== 1) begin errors++; $display("FAIL wr_busy: got %0d expected 1", low); end
    issue(2'b01, 25'd3, 16'h0000, low);
    checks++; if (low !== 2) begin errors++; $display("FAIL rd_busy: got %0d expected 2", low); end
    checks++; if (bus.memOut !== 16'hBEEF) begin errors++; $display("FAIL rd_data3: got %h expected beef", bus.memOut); end
    issue(2'b10, 25'd15, 16'hA5A5, low);
    issue(2'b01, 25'd15, 16'h0000, low);
    checks++; if (bus.memOut !== 16'hA5A5) begin errors++; $display("FAIL rd_data15: got %h expected a5a5", bus.memOut); end
  endtask

  task automatic test_reset_midrun();
    bus.modeOutput = 2'b00; bus.memoryAddress = '0; bus.ioDone = 1'b1;
    @(negedge clk);
    bus.ioDone = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.memDone !== 1'b0) begin errors++; $display("FAIL midrun_busy: got %b expected 0", bus.memDone); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.memDone !== 1'b1) begin errors++; $display("FAIL midrun_memDone: got %b expected 1", bus.memDone); end
    checks++; if (bus.memOut !== 16'h0000) begin errors++; $display("FAIL midrun_memOut: got %h expected 0000", bus.memOut); end
    checks++; if (bus.errFlag !== 1'b0) begin errors++; $display("FAIL midrun_errFlag: got %b expected 0", bus.errFlag); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clear();
    int low;
    issue(2'b10, 25'd3, 16'h1234, low);
    issue(2'b10, 25'd15, 16'hCAFE, low);
    issue(2'b01, 25'd3, 16'h0000, low);
    checks++; if (bus.memOut !== 16'h1234) begin errors++; $display("FAIL clr_pre: got %h expected 1234", bus.memOut); end
    issue(2'b00, 25'd0, 16'h0000, low);
    checks++; if (low !== 16) begin errors++; $display("FAIL clr_busy: got %0d expected 16", low); end
    checks++; if (bus.memOut !== 16'h0000) begin errors++; $display("FAIL clr_memOut: got %h expected 0000", bus.memOut); end
    issue(2'b01, 25'd3, 16'h0000, low);
    checks++; if (bus.memOut !== 16'h0000) begin errors++; $display("FAIL clr_rd3: got %h expected 0000", bus.memOut); end
    issue(2'b01, 25'd15, 16'h0000, low);
    checks++; if (bus.memOut !== 16'h0000) begin errors++; $display("FAIL clr_rd15: got %h expected 0000", bus.memOut); end
  endtask

  task automatic test_held();
    int lows;
    int low;
    bus.modeOutput = 2'b10; bus.memoryAddress = 25'd5; bus.ioDataOut = 16'h1111; bus.ioDone = 1'b1;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) bus.ioDataOut = 16'h2222;
      if (bus.memDone === 1'b0) lows++;
    end
    bus.ioDone = 1'b0;
    @(negedge clk);
    checks++; if (lows !== 1) begin errors++; $display("FAIL held_busy: got %0d expected 1", lows); end
    issue(2'b01, 25'd5, 16'h0000, low);
    checks++; if (bus.memOut !== 16'h1111) begin errors++; $display("FAIL held_data: got %h expected 1111", bus.memOut); end
    // read, then a second rising edge (a write) while the read is still busy
    bus.modeOutput = 2'b01; bus.ioDone = 1'b1;
    lows = 0;
    @(negedge clk);
    if (bus.memDone === 1'b0) lows++;
    bus.ioDone = 1'b0; bus.modeOutput = 2'b10; bus.ioDataOut = 16'h3333;
    @(negedge clk);
    if (bus.memDone === 1'b0) lows++;
    bus.ioDone = 1'b1;
    @(negedge clk);
    if (bus.memDone === 1'b0) lows++;
    bus.ioDone = 1'b0;
    checks++; if (bus.memOut !== 16'h1111) begin errors++; $display("FAIL busy_edge_rd: got %h expected 1111", bus.memOut); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.memDone === 1'b0) lows++;
    end
    checks++; if (lows !== 2) begin errors++; $display("FAIL busy_edge_lows: got %0d expected 2", lows); end
    issue(2'b01, 25'd5, 16'h0000, low);
    checks++; if (bus.memOut !== 16'h1111) begin errors++; $display("FAIL busy_edge_ram: got %h expected 1111", bus.memOut); end
  endtask

  task automatic test_back_to_back();
    int low;
    issue(2'b10, 25'd7, 16'h7777, low);
    issue(2'b01, 25'd7, 16'h0000, low);
    checks++; if (low !== 2) begin errors++; $display("FAIL b2b_rd_busy: got %0d expected 2", low); end
    checks++; if (bus.memOut !== 16'h7777) begin errors++; $display("FAIL b2b_rd1: got %h expected 7777", bus.memOut); end
    issue(2'b10, 25'd7, 16'h0F0F, low);
    checks++; if (low !== 1) begin errors++; $display("FAIL b2b_wr_busy: got %0d expected 1", low); end
    issue(2'b01, 25'd7, 16'h0000, low);
    checks++; if (bus.memOut !== 16'h0F0F) begin errors++; $display("FAIL b2b_rd2: got %h expected 0f0f", bus.memOut); end
  endtask

  task automatic test_oor();
    int low;
    issue(2'b10, 25'd3, 16'hABCD, low);
    issue(2'b10, 25'h13, 16'h5555, low);
    checks++; if (low !== 1) begin errors++; $display("FAIL oor_busy: got %0d expected 1", low); end
`ifdef MEM_OOR_EN
    checks++; if (bus.errFlag !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", bus.errFlag); end
    issue(2'b01, 25'd3, 16'h0000, low);
    checks++; if (bus.memOut !== 16'hABCD) begin errors++; $display("FAIL oor_ram3: got %h expected abcd", bus.memOut); end
    issue(2'b01, 25'h13, 16'h0000, low);
    checks++; if (low !== 1) begin errors++; $display("FAIL oor_rd_busy: got %0d expected 1", low); end
    checks++; if (bus.memOut !== 16'hABCD) begin errors++; $display("FAIL oor_rd_hold: got %h expected abcd", bus.memOut); end
    issue(2'b00, 25'd0, 16'h0000, low);
    checks++; if (bus.errFlag !== 1'b0) begin errors++; $display("FAIL oor_err_clr: got %b expected 0", bus.errFlag); end
`else
    checks++; if (bus.errFlag !== 1'b0) begin errors++; $display("FAIL oor_err: got %b expected 0", bus.errFlag); end
    issue(2'b01, 25'd3, 16'h0000, low);
    checks++; if (bus.memOut !== 16'h5555) begin errors++; $display("FAIL oor_ram3: got %h expected 5555", bus.memOut); end
    issue(2'b01, 25'h13, 16'h0000, low);
    checks++; if (low !== 2) begin errors++; $display("FAIL oor_rd_busy: got %0d expected 2", low); end
    checks++; if (bus.memOut !== 16'h5555) begin errors++; $display("FAIL oor_rd_wrap: got %h expected 5555", bus.memOut); end
`endif
  endtask

  task automatic test_noop();
    int low;
    issue(2'b10, 25'd3, 16'h4242, low);
    issue(2'b01, 25'd3, 16'h0000, low);
    issue(2'b11, 25'd3, 16'h9999, low);
    checks++; if (low !== 0) begin errors++; $display("FAIL noop_busy: got %0d expected 0", low); end
    checks++; if (bus.memOut !== 16'h4242) begin errors++; $display("FAIL noop_memOut: got %h expected 4242", bus.memOut); end
    issue(2'b01, 25'd3, 16'h0000, low);
    checks++; if (bus.memOut !== 16'h4242) begin errors++; $display("FAIL noop_ram: got %h expected 4242", bus.memOut); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reset_midrun();
    test_clear();
    test_held();
    test_back_to_back();
    test_oor();
    test_noop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
